// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

   localparam int STAT_W     = 32;
   localparam int CMD_ADDR_W = 25;
   localparam int CMD_DATA_W = 16;

   typedef enum logic [2:0] {
      CLS_URGENT,
      CLS_HIT_WR,
      CLS_HIT_RD,
      CLS_NEW_WR,
      CLS_NEW_RD,
      CLS_NONE
   } arb_class_e;

   typedef struct packed {
      logic                  is_write;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] data;
   } arb_cmd_t;

   function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Request-port and command-FIFO signal bundle for the SDRAM port arbiter.
interface sdram_port_arbiter_if #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 25,
   parameter int DATA_W    = 16,
   localparam int PTR_W    = $clog2(NUM_PORTS)
);
   logic [NUM_PORTS-1:0]        req_valid;
   logic [NUM_PORTS-1:0]        req_is_write;
   logic [NUM_PORTS*ADDR_W-1:0] req_addr;
   logic [NUM_PORTS*DATA_W-1:0] req_data;
   logic [NUM_PORTS-1:0]        req_urgent;
   logic [NUM_PORTS-1:0]        req_ready;

   logic                        cmd_full;
   logic                        cmd_valid;
   logic                        cmd_is_write;
   logic [ADDR_W-1:0]           cmd_addr;
   logic [DATA_W-1:0]           cmd_data;
   logic [PTR_W-1:0]            cmd_port;

   modport arb (
      input  req_valid, req_is_write, req_addr, req_data, req_urgent, cmd_full,
      output req_ready, cmd_valid, cmd_is_write, cmd_addr, cmd_data, cmd_port
   );

   modport src (
      output req_valid, req_is_write, req_addr, req_data, req_urgent, cmd_full,
      input  req_ready, cmd_valid, cmd_is_write, cmd_addr, cmd_data, cmd_port
   );
endinterface

// File: rtl/sdram_arb_rr_pick.sv
// Combinational rotate-priority picker: first set mask bit at or after ptr, wrapping.
module sdram_arb_rr_pick #(
   parameter int NUM_PORTS = 4,
   localparam int PTR_W    = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] mask,
   input  logic [PTR_W-1:0]     ptr,
   output logic                 any,
   output logic [NUM_PORTS-1:0] onehot,
   output logic [PTR_W-1:0]     index
);
   int slot;

   always_comb begin
      any    = 1'b0;
      onehot = '0;
      index  = '0;
      slot   = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         slot = int'(ptr) + i;
         if (slot >= NUM_PORTS) slot = slot - NUM_PORTS;
         if (!any && mask[slot]) begin
            any          = 1'b1;
            onehot[slot] = 1'b1;
            index        = PTR_W'(slot);
         end
      end
   end
endmodule

// File: rtl/sdram_port_arbiter.sv
// N-port SDRAM command arbiter: urgency, row-hit and turnaround aware, with aging.
// Optional performance counters are built when SDRAM_ARB_STATS_EN is defined.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 25,
   parameter int DATA_W    = 16,
   parameter int ROW_LSB   = 10,
   parameter int AGE_W     = 8,
   parameter int AGE_LIMIT = 64,
   localparam int PTR_W    = $clog2(NUM_PORTS),
   localparam int ROW_W    = ADDR_W - ROW_LSB
) (
   input  logic                 clk,
   input  logic                 rst,
   sdram_port_arbiter_if.arb    bus,
   output logic [ROW_W-1:0]     present_row,
   output logic                 last_was_write,
   output logic [STAT_W-1:0]    stat_row_hits,
   output logic [STAT_W-1:0]    stat_row_misses,
   output logic [STAT_W-1:0]    stat_turnarounds
);
   localparam int NUM_CLS = 5;

   logic [NUM_PORTS-1:0] row_hit;
   logic [NUM_PORTS-1:0] cls_mask   [NUM_CLS];
   logic                 cls_any    [NUM_CLS];
   logic [NUM_PORTS-1:0] cls_onehot [NUM_CLS];
   logic [PTR_W-1:0]     cls_idx    [NUM_CLS];

   arb_class_e           gnt_class;
   logic [NUM_PORTS-1:0] gnt_onehot;
   logic [PTR_W-1:0]     gnt_idx;
   logic                 grant;

   logic [AGE_W-1:0]     age_q [NUM_PORTS];
   logic [AGE_W-1:0]     age_d [NUM_PORTS];
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ROW_W-1:0]     present_row_q, present_row_d;
   logic                 lww_q, lww_d;
   logic                 cmd_valid_q, cmd_valid_d;
   logic                 cmd_is_write_q, cmd_is_write_d;
   logic [ADDR_W-1:0]    cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0]    cmd_data_q, cmd_data_d;
   logic [PTR_W-1:0]     cmd_port_q, cmd_port_d;

   // A row-hit write following a read has no dedicated class; it competes with new-row writes.
   always_comb begin
      for (int c = 0; c < NUM_CLS; c++) cls_mask[c] = '0;
      row_hit = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         row_hit[p] = (bus.req_addr[p*ADDR_W+ROW_LSB +: ROW_W] == present_row_q);
         cls_mask[CLS_URGENT][p] = bus.req_valid[p] &
                                   (bus.req_urgent[p] | (int'(age_q[p]) >= AGE_LIMIT));
         cls_mask[CLS_HIT_WR][p] = bus.req_valid[p] & row_hit[p] & bus.req_is_write[p] & lww_q;
         cls_mask[CLS_HIT_RD][p] = bus.req_valid[p] & row_hit[p] & ~bus.req_is_write[p];
         cls_mask[CLS_NEW_WR][p] = bus.req_valid[p] & bus.req_is_write[p] & ~(row_hit[p] & lww_q);
         cls_mask[CLS_NEW_RD][p] = bus.req_valid[p] & ~row_hit[p] & ~bus.req_is_write[p];
      end
   end

   for (genvar c = 0; c < NUM_CLS; c++) begin : g_pick
      sdram_arb_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
         .mask   (cls_mask[c]),
         .ptr    (rr_ptr_q),
         .any    (cls_any[c]),
         .onehot (cls_onehot[c]),
         .index  (cls_idx[c])
      );
   end

   // Scan from the lowest-priority class upward so the highest non-empty class wins.
   always_comb begin
      gnt_class  = CLS_NONE;
      gnt_onehot = '0;
      gnt_idx    = '0;
      for (int c = NUM_CLS - 1; c >= 0; c--) begin
         if (cls_any[c]) begin
            gnt_class  = arb_class_e'(3'(c));
            gnt_onehot = cls_onehot[c];
            gnt_idx    = cls_idx[c];
         end
      end
   end

   assign grant         = rst && !bus.cmd_full && (gnt_class != CLS_NONE);
   assign bus.req_ready = grant ? gnt_onehot : '0;

   always_comb begin
      rr_ptr_d       = rr_ptr_q;
      present_row_d  = present_row_q;
      lww_d          = lww_q;
      cmd_valid_d    = grant;
      cmd_is_write_d = cmd_is_write_q;
      cmd_addr_d     = cmd_addr_q;
      cmd_data_d     = cmd_data_q;
      cmd_port_d     = cmd_port_q;
      if (grant) begin
         rr_ptr_d       = (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
         cmd_is_write_d = bus.req_is_write[gnt_idx];
         cmd_addr_d     = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
         cmd_data_d     = bus.req_data[gnt_idx*DATA_W +: DATA_W];
         cmd_port_d     = gnt_idx;
         present_row_d  = bus.req_addr[gnt_idx*ADDR_W+ROW_LSB +: ROW_W];
         lww_d          = bus.req_is_write[gnt_idx];
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         age_d[p] = age_q[p];
         if (!bus.req_valid[p] || bus.req_ready[p]) age_d[p] = '0;
         else if (!bus.cmd_full && !(&age_q[p])) age_d[p] = age_q[p] + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_q       <= '0;
         present_row_q  <= '0;
         lww_q          <= 1'b1;
         cmd_valid_q    <= 1'b0;
         cmd_is_write_q <= 1'b0;
         cmd_addr_q     <= '0;
         cmd_data_q     <= '0;
         cmd_port_q     <= '0;
         for (int p = 0; p < NUM_PORTS; p++) age_q[p] <= '0;
      end else begin
         rr_ptr_q       <= rr_ptr_d;
         present_row_q  <= present_row_d;
         lww_q          <= lww_d;
         cmd_valid_q    <= cmd_valid_d;
         cmd_is_write_q <= cmd_is_write_d;
         cmd_addr_q     <= cmd_addr_d;
         cmd_data_q     <= cmd_data_d;
         cmd_port_q     <= cmd_port_d;
         for (int p = 0; p < NUM_PORTS; p++) age_q[p] <= age_d[p];
      end
   end

   assign bus.cmd_valid    = cmd_valid_q;
   assign bus.cmd_is_write = cmd_is_write_q;
   assign bus.cmd_addr     = cmd_addr_q;
   assign bus.cmd_data     = cmd_data_q;
   assign bus.cmd_port     = cmd_port_q;
   assign present_row      = present_row_q;
   assign last_was_write   = lww_q;

`ifdef SDRAM_ARB_STATS_EN
   logic [STAT_W-1:0] stat_hits_q, stat_hits_d;
   logic [STAT_W-1:0] stat_miss_q, stat_miss_d;
   logic [STAT_W-1:0] stat_turn_q, stat_turn_d;

   always_comb begin
      stat_hits_d = stat_hits_q;
      stat_miss_d = stat_miss_q;
      stat_turn_d = stat_turn_q;
      if (grant) begin
         if (row_hit[gnt_idx]) stat_hits_d = stat_inc(stat_hits_q);
         else                  stat_miss_d = stat_inc(stat_miss_q);
         if (!lww_q && bus.req_is_write[gnt_idx]) stat_turn_d = stat_inc(stat_turn_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_hits_q <= '0;
         stat_miss_q <= '0;
         stat_turn_q <= '0;
      end else begin
         stat_hits_q <= stat_hits_d;
         stat_miss_q <= stat_miss_d;
         stat_turn_q <= stat_turn_d;
      end
   end

   assign stat_row_hits    = stat_hits_q;
   assign stat_row_misses  = stat_miss_q;
   assign stat_turnarounds = stat_turn_q;
`else
   assign stat_row_hits    = '0;
   assign stat_row_misses  = '0;
   assign stat_turnarounds = '0;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: latency, class priority, round-robin, aging, back-pressure, reset, stats.
module tb_sdram_port_arbiter;
   localparam int NP = 4;
   localparam int AW = 25;
   localparam int DW = 16;

   logic          clk;
   logic          rst;
   logic          full;
   logic [NP-1:0] v, w, u;
   logic [AW-1:0] a [NP];
   logic [DW-1:0] d [NP];
   logic [AW-11:0] present_row;
   logic          last_was_write;
   logic [31:0]   stat_row_hits, stat_row_misses, stat_turnarounds;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_hits, exp_miss, exp_turn;

   sdram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

   assign bus.req_valid    = v;
   assign bus.req_is_write = w;
   assign bus.req_urgent   = u;
   assign bus.req_addr     = {a[3], a[2], a[1], a[0]};
   assign bus.req_data     = {d[3], d[2], d[1], d[0]};
   assign bus.cmd_full     = full;

   sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ROW_LSB(10),
                        .AGE_W(8), .AGE_LIMIT(64)) dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus),
      .present_row      (present_row),
      .last_was_write   (last_was_write),
      .stat_row_hits    (stat_row_hits),
      .stat_row_misses  (stat_row_misses),
      .stat_turnarounds (stat_turnarounds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst  = 1'b0;
      full = 1'b0;
      v = '0; w = '0; u = '0;
      for (int p = 0; p < NP; p++) begin a[p] = '0; d[p] = '0; end

      // reset, with a request present
      v = 4'b0010; a[1] = 25'h400;
      tick; tick;
      #1;
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_cmd_valid", bus.cmd_valid, 0);
      chk("rst_cmd_addr", bus.cmd_addr, 0);
      chk("rst_cmd_port", bus.cmd_port, 0);
      chk("rst_present_row", present_row, 0);
      chk("rst_lww", last_was_write, 1);
      chk("rst_stat_hits", stat_row_hits, 0);

      // basic latency
      rst = 1'b1; d[1] = 16'hBEEF;
      #1 chk("basic_ready", bus.req_ready, 4'b0010);
      tick;
      chk("basic_valid", bus.cmd_valid, 1);
      chk("basic_addr", bus.cmd_addr, 25'h400);
      chk("basic_port", bus.cmd_port, 1);
      chk("basic_data", bus.cmd_data, 16'hBEEF);
      chk("basic_is_write", bus.cmd_is_write, 0);
      chk("basic_row", present_row, 1);
      chk("basic_lww", last_was_write, 0);

      // idle cycle: no grant
      v = '0;
      #1 chk("idle_ready", bus.req_ready, 0);
      tick;
      chk("idle_valid", bus.cmd_valid, 0);

      // set up row 1 with a write
      v = 4'b1000; w = 4'b1000; a[3] = 25'h402;
      #1 chk("setup_ready", bus.req_ready, 4'b1000);
      tick;
      chk("setup_lww", last_was_write, 1);
      chk("setup_row", present_row, 1);

      // turnaround preference: hit write beats hit read after a write
      v = 4'b0101; w = 4'b0100; a[0] = 25'h400; a[2] = 25'h401;
      #1 chk("turn_ready0", bus.req_ready, 4'b0100);
      tick;
      chk("turn_port0", bus.cmd_port, 2);
      chk("turn_addr0", bus.cmd_addr, 25'h401);
      v = 4'b0001;
      #1 chk("turn_ready1", bus.req_ready, 4'b0001);
      tick;
      chk("turn_port1", bus.cmd_port, 0);
      chk("turn_wr1", bus.cmd_is_write, 0);

      // round-robin: rr pointer is 1 after the port-0 grant
      v = 4'b1111; w = 4'b1111;
      for (int p = 0; p < NP; p++) a[p] = AW'(p);
      for (int k = 0; k < 8; k++) begin
         #1 chk($sformatf("rr_ready%0d", k), bus.req_ready, 64'(1) << ((1 + k) % 4));
         tick;
         chk($sformatf("rr_port%0d", k), bus.cmd_port, (1 + k) % 4);
      end

      v = '0;
      tick;

      // aging: port 3 reads row 5 against row-0 write hits on ports 0-2
      v = 4'b1111; w = 4'b0111; a[3] = 25'h1400;
      for (int k = 1; k <= 64; k++) begin
         #1 chk($sformatf("age_ready%0d", k), bus.req_ready, 64'(1) << (k % 3));
         tick;
      end
      #1 chk("age_grant", bus.req_ready, 4'b1000);
      tick;
      chk("age_port", bus.cmd_port, 3);
      chk("age_row", present_row, 5);
      a[3] = 25'h1800;
      #1 chk("age_cleared", bus.req_ready, 4'b0001);
      tick;

      // back-pressure: ages frozen, port 3 sits at age 1
      full = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #1 chk($sformatf("full_ready%0d", k), bus.req_ready, 0);
         tick;
         chk($sformatf("full_valid%0d", k), bus.cmd_valid, 0);
      end
      full = 1'b0;
      for (int r = 1; r <= 63; r++) begin
         #1 chk($sformatf("thaw_ready%0d", r), bus.req_ready, 64'(1) << (r % 3));
         tick;
      end
      #1 chk("thaw_grant", bus.req_ready, 4'b1000);
      tick;
      chk("thaw_port", bus.cmd_port, 3);

      // mid-stream reset
      rst = 1'b0;
      #1 chk("mrst_ready", bus.req_ready, 0);
      tick;
      chk("mrst_valid", bus.cmd_valid, 0);
      chk("mrst_lww", last_was_write, 1);
      chk("mrst_row", present_row, 0);
      chk("mrst_port", bus.cmd_port, 0);

      // stats: write r0, read r0, write r0, read r7
      rst = 1'b1;
      v = 4'b0001; w = 4'b0001; a[0] = 25'h0;
      #1 chk("st_ready", bus.req_ready, 4'b0001);
      tick;
      w = 4'b0000; tick;
      w = 4'b0001; tick;
      w = 4'b0000; a[0] = 25'h1C00; tick;
      v = '0; tick;
      chk("st_row", present_row, 7);
`ifdef SDRAM_ARB_STATS_EN
      exp_hits = 3; exp_miss = 1; exp_turn = 1;
`else
      exp_hits = 0; exp_miss = 0; exp_turn = 0;
`endif
      chk("st_hits", stat_row_hits, exp_hits);
      chk("st_miss", stat_row_misses, exp_miss);
      chk("st_turn", stat_turnarounds, exp_turn);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
